// File: rtl/tensor_stream_register.sv
// Parametrised ROWSxCOLS tensor register with indexed loads and a valid/ready streaming fill.
// Optional TENSOR_TRANSPOSE_EN adds a column-major output image and column-major stream ordering.
module tensor_stream_register #(
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned ROWS   = 3,
  parameter int unsigned COLS   = 3,
  parameter int unsigned IDX_W  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          load,
  input  logic [IDX_W-1:0]              idx,
  input  logic [ELEM_W-1:0]             element,
  input  logic                          start,
  input  logic                          s_valid,
  input  logic [ELEM_W-1:0]             s_data,
`ifdef TENSOR_TRANSPOSE_EN
  input  logic                          s_col_major,
  output logic [ROWS*COLS*ELEM_W-1:0]   tensor_t_out,
`endif
  output logic                          s_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          full,
  output logic [IDX_W-1:0]              wr_ptr,
  output logic [ROWS*COLS*ELEM_W-1:0]   tensor_out
);

  localparam int unsigned N = ROWS * COLS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state_q, state_d;
  logic [ELEM_W-1:0]   mem [N];
  logic                accept;
  logic                last;
  logic [IDX_W-1:0]    stream_slot;
  logic                col_major_q;

  assign accept = s_valid && (state_q == FILL);
  assign last   = (int'(wr_ptr) == int'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (start) state_d = FILL;
    end else begin
      if (accept && last) state_d = IDLE;
    end
    if (clear) state_d = IDLE;
  end

  always_comb begin
    busy    = (state_q == FILL);
    s_ready = (state_q == FILL);
  end

`ifdef TENSOR_TRANSPOSE_EN
  // Column-major stream order: element k lands at row k%ROWS, column k/ROWS.
  always_comb begin
    stream_slot = wr_ptr;
    if (col_major_q)
      stream_slot = IDX_W'((int'(wr_ptr) % int'(ROWS)) * int'(COLS) + int'(wr_ptr) / int'(ROWS));
  end
`else
  always_comb stream_slot = wr_ptr;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem         <= '{default: '0};
      wr_ptr      <= '0;
      full        <= 1'b0;
      done        <= 1'b0;
      col_major_q <= 1'b0;
    end else if (clear) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      full   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          wr_ptr <= '0;
          full   <= 1'b0;
`ifdef TENSOR_TRANSPOSE_EN
          col_major_q <= s_col_major;
`else
          col_major_q <= 1'b0;
`endif
        end else if (load && (int'(idx) < int'(N))) begin
          mem[idx] <= element;
        end
      end else if (accept) begin
        mem[stream_slot] <= s_data;
        if (last) begin
          wr_ptr <= '0;
          done   <= 1'b1;
          full   <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

  always_comb begin
    tensor_out = '0;
    for (int unsigned k = 0; k < N; k++)
      tensor_out[k*ELEM_W +: ELEM_W] = mem[k];
  end

`ifdef TENSOR_TRANSPOSE_EN
  // Pure rewiring of the registered array, so it tracks tensor_out edge for edge.
  always_comb begin
    tensor_t_out = '0;
    for (int unsigned r = 0; r < ROWS; r++)
      for (int unsigned c = 0; c < COLS; c++)
        tensor_t_out[(c*ROWS + r)*ELEM_W +: ELEM_W] = mem[r*COLS + c];
  end
`endif

endmodule

// File: tb/tb_tensor_stream_register.sv
// Directed sequence with randomized data for tensor_stream_register, checked against an array model.
// Covers loads, streaming fills, stalls, clear abort and async reset; TENSOR_TRANSPOSE_EN adds column-major checks.
module tb_tensor_stream_register;

  localparam int unsigned ELEM_W = 16;
  localparam int unsigned ROWS   = 3;
  localparam int unsigned COLS   = 3;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned N      = ROWS * COLS;

  logic                      clk = 1'b0;
  logic                      reset, clear, load, start, s_valid, s_col_major;
  logic [IDX_W-1:0]          idx;
  logic [ELEM_W-1:0]         element, s_data;
  logic                      s_ready, busy, done, full;
  logic [IDX_W-1:0]          wr_ptr;
  logic [N*ELEM_W-1:0]       tensor_out;
`ifdef TENSOR_TRANSPOSE_EN
  logic [N*ELEM_W-1:0]       tensor_t_out;
`endif

  logic [ELEM_W-1:0] model [N];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  tensor_stream_register #(.ELEM_W(ELEM_W), .ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .idx(idx), .element(element),
    .start(start), .s_valid(s_valid), .s_data(s_data),
`ifdef TENSOR_TRANSPOSE_EN
    .s_col_major(s_col_major), .tensor_t_out(tensor_t_out),
`endif
    .s_ready(s_ready), .busy(busy), .done(done), .full(full), .wr_ptr(wr_ptr),
    .tensor_out(tensor_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [N*ELEM_W-1:0] flat();
    logic [N*ELEM_W-1:0] v = '0;
    for (int unsigned k = 0; k < N; k++) v[k*ELEM_W +: ELEM_W] = model[k];
    return v;
  endfunction

  function automatic int unsigned slot_of(input int unsigned k, input bit colmaj);
    return colmaj ? (k % ROWS) * COLS + k / ROWS : k;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_tensor"}, tensor_out, '0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sready"}, s_ready, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_wrptr"}, wr_ptr, 0);
  endtask

  // base != 0 gives data base+k, otherwise random; gapped stalls alternate cycles; poke drives load/start mid-fill.
  task automatic run_fill(input int unsigned base, input bit gapped, input bit poke, input bit colmaj);
    int unsigned k = 0;
    int unsigned cyc = 0;
    int unsigned done_count = 0;
    start = 1'b1; s_col_major = colmaj;
    if (poke) begin load = 1'b1; idx = IDX_W'(N - 1); element = 16'hBEEF; end
    tick();
    start = 1'b0; load = 1'b0;
    check("start_busy", busy, 1);
    check("start_sready", s_ready, 1);
    check("start_wrptr", wr_ptr, 0);
    check("start_full_cleared", full, 0);
    check("start_load_dropped", tensor_out, flat());
    while (k < N && cyc < 100) begin
      s_valid = gapped ? (cyc % 2 == 1) : 1'b1;
      s_data  = (base != 0) ? ELEM_W'(base + k) : ELEM_W'($urandom);
      if (poke) begin
        load    = 1'($urandom);
        idx     = IDX_W'($urandom_range(0, N - 1));
        element = ELEM_W'($urandom);
        start   = 1'($urandom);
      end
      tick();
      cyc++;
      if (s_valid) begin
        model[slot_of(k, colmaj)] = s_data;
        k++;
      end
      s_valid = 1'b0; load = 1'b0; start = 1'b0;
      if (done) done_count++;
      if (k < N) check("fill_wrptr", wr_ptr, k);
      check("fill_busy", busy, k < N);
    end
    check("fill_completed_in_budget", k, N);
    check("fill_done_count", done_count, 1);
    check("fill_done_now", done, 1);
    check("fill_full", full, 1);
    check("fill_wrptr_wrap", wr_ptr, 0);
    check("fill_sready_low", s_ready, 0);
    check("fill_tensor", tensor_out, flat());
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; load = 1'b0; start = 1'b0; s_valid = 1'b0;
    s_col_major = 1'b0; idx = '0; element = '0; s_data = '0;
    for (int unsigned k = 0; k < N; k++) model[k] = '0;
    #2;
    check_idle_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    for (int unsigned k = 0; k < N; k++) begin
      load = 1'b1; idx = IDX_W'(k); element = ELEM_W'(16'h1000 + k);
      tick();
      model[k] = element;
      check("load_seq", tensor_out, flat());
    end
    load = 1'b0;
    check("load_pattern", tensor_out, 144'h1008_1007_1006_1005_1004_1003_1002_1001_1000);
    check("load_full_stays", full, 0);

    load = 1'b1; idx = IDX_W'(9); element = 16'hDEAD;
    tick();
    load = 1'b0;
    check("load_oob_dropped", tensor_out, flat());

    for (int unsigned i = 0; i < 12; i++) begin
      load = 1'b1; idx = IDX_W'($urandom_range(0, 15)); element = ELEM_W'($urandom);
      s_valid = 1'($urandom); s_data = ELEM_W'($urandom);
      tick();
      if (int'(idx) < int'(N)) model[idx] = element;
      check("load_rand", tensor_out, flat());
      check("load_rand_sready", s_ready, 0);
    end
    load = 1'b0; s_valid = 1'b0;

    run_fill(16'hA0, 1'b0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < N; k++) check("fill_slot_a0", model[k], ELEM_W'(16'hA0 + k));
    tick();
    check("done_one_cycle", done, 0);
    check("full_sticky", full, 1);

    run_fill(0, 1'b1, 1'b1, 1'b0);
    // Starts while done is still high from the previous fill.
    start = 1'b1; tick(); start = 1'b0;
    check("start_in_done_cycle", busy, 1);
    for (int unsigned k = 0; k < 4; k++) begin
      s_valid = 1'b1; s_data = ELEM_W'($urandom); tick();
    end
    clear = 1'b1; s_valid = 1'b1; tick(); clear = 1'b0; s_valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) model[k] = '0;
    check_idle_zero("clear");
    tick();
    check("clear_no_done", done, 0);
    run_fill(0, 1'b0, 1'b0, 1'b0);
    tick();

    start = 1'b1; tick(); start = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = ELEM_W'($urandom); tick();
    end
    s_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    for (int unsigned k = 0; k < N; k++) model[k] = '0;
    check_idle_zero("async_reset");
`ifdef TENSOR_TRANSPOSE_EN
    check("async_reset_t", tensor_t_out, '0);
`endif
    reset = 1'b0;
    tick();

`ifdef TENSOR_TRANSPOSE_EN
    run_fill(0, 1'b0, 1'b0, 1'b1);
    for (int unsigned k = 0; k < N; k++) model[k] = '0;
    s_col_major = 1'b1; start = 1'b1; tick(); start = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      s_valid = 1'b1; s_data = ELEM_W'(k); tick();
      model[slot_of(k, 1'b1)] = ELEM_W'(k);
    end
    s_valid = 1'b0;
    check("colmaj_tensor", tensor_out, flat());
    check("colmaj_slot1", tensor_out[1*ELEM_W +: ELEM_W], 3);
    check("colmaj_t_slot1", tensor_t_out[1*ELEM_W +: ELEM_W], 1);
    for (int unsigned r = 0; r < ROWS; r++)
      for (int unsigned c = 0; c < COLS; c++)
        check("colmaj_t_image", tensor_t_out[(c*ROWS + r)*ELEM_W +: ELEM_W], model[r*COLS + c]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
